fault_detect: RTL and testbench

FAULT_DETECT -- requirements
Module: fault_detect

---
 rtl/fault_detect.sv | 190 +++++++++++++++++++
 tb/tb_fault_detect.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fault_detect.sv
// fault_detect: debounced overcurrent / DC-link over/undervoltage and
// gate-driver pin fault detection with an active-low registered fault vector.
// Optional build macro UV_STARTUP_MASK_EN: adds a PRECHARGE/RUN FSM that masks
// undervoltage until the DC link has charged; without it, undervoltage is
// monitored from reset.
module fault_detect #(
  parameter int I_MAX   = 1800,
  parameter int U_MAX   = 3500,
  parameter int U_MIN   = 500,
  parameter int DEB_N   = 4,
  parameter int PIN_DEB = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        adc_valid,
  input  logic [11:0] i_a,
  input  logic [11:0] i_b,
  input  logic [11:0] i_c,
  input  logic [11:0] u_dc,
  input  logic [2:0]  drv_fault_n,
  output logic [7:0]  error,
  output logic        any_fault
);

  localparam logic [12:0] I_LIM    = 13'(I_MAX);
  localparam logic [11:0] U_HI     = 12'(U_MAX);
  localparam logic [11:0] U_LO     = 12'(U_MIN);
  localparam logic [3:0]  DEB_C    = 4'(DEB_N);
  localparam logic [15:0] PIN_LAST = 16'(PIN_DEB - 1);

  // 13-bit magnitude so that -2048 maps to +2048 instead of wrapping.
  function automatic logic [12:0] mag13(input logic [11:0] v);
    logic [12:0] ext;
    ext = {v[11], v};
    if (v[11]) begin
      mag13 = 13'd0 - ext;
    end else begin
      mag13 = ext;
    end
  endfunction

  logic [4:0]  w_trip;
  logic        w_uv_mask;
  logic [4:0]  w_clr;
  logic [7:0]  w_err_nxt;
  logic [3:0]  w_cnt_nxt [5];
  logic [15:0] w_pin_cnt_nxt [3];

  logic [2:0]  r_sync1;
  logic [2:0]  r_sync2;
  logic [3:0]  r_cnt [5];
  logic [15:0] r_pin_cnt [3];
  logic [7:0]  r_error;
  logic        r_any;

  assign w_trip[0] = (mag13(i_a) > I_LIM);
  assign w_trip[1] = (mag13(i_b) > I_LIM);
  assign w_trip[2] = (mag13(i_c) > I_LIM);
  assign w_trip[3] = (u_dc > U_HI);
  assign w_trip[4] = (u_dc < U_LO);

`ifdef UV_STARTUP_MASK_EN
  typedef enum logic {PRECHARGE = 1'b0, RUN = 1'b1} state_t;
  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_pc_cnt;
  logic [3:0]  w_pc_cnt_nxt;

  // FSM state and precharge-qualification counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= PRECHARGE;
      r_pc_cnt <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc_cnt <= w_pc_cnt_nxt;
    end
  end

  // Leave PRECHARGE after DEB_N consecutive valid samples at or above U_MIN.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_cnt_nxt = r_pc_cnt;
    case (r_state)
      PRECHARGE: begin
        if (adc_valid) begin
          if (u_dc >= U_LO) begin
            if (r_pc_cnt == (DEB_C - 4'd1)) begin
              w_state_nxt  = RUN;
              w_pc_cnt_nxt = 4'd0;
            end else begin
              w_pc_cnt_nxt = r_pc_cnt + 4'd1;
            end
          end else begin
            w_pc_cnt_nxt = 4'd0;
          end
        end else begin
          w_pc_cnt_nxt = r_pc_cnt;
        end
      end
      RUN: begin
        w_state_nxt  = RUN;
        w_pc_cnt_nxt = 4'd0;
      end
      default: begin
        w_state_nxt  = PRECHARGE;
        w_pc_cnt_nxt = 4'd0;
      end
    endcase
  end

  // Undervoltage is masked while the DC link is still precharging.
  always_comb begin
    case (r_state)
      PRECHARGE: w_uv_mask = 1'b1;
      RUN:       w_uv_mask = 1'b0;
      default:   w_uv_mask = 1'b1;
    endcase
  end
`else
  assign w_uv_mask = 1'b0;
`endif

  assign w_clr = {w_uv_mask, 4'b0000};

  // Next counter values and next fault vector for analog channels and pins.
  always_comb begin
    w_err_nxt = r_error;
    for (int ch = 0; ch < 5; ch++) begin
      if (w_clr[ch]) begin
        w_cnt_nxt[ch] = 4'd0;
      end else if (adc_valid) begin
        if (!w_trip[ch]) begin
          w_cnt_nxt[ch] = 4'd0;
        end else if (r_cnt[ch] == DEB_C) begin
          w_cnt_nxt[ch] = r_cnt[ch];
        end else begin
          w_cnt_nxt[ch] = r_cnt[ch] + 4'd1;
        end
      end else begin
        w_cnt_nxt[ch] = r_cnt[ch];
      end
      w_err_nxt[ch] = (w_cnt_nxt[ch] != DEB_C);
    end
    // A pin bit flips once the synchronized level has disagreed with it
    // for PIN_DEB consecutive cycles; agreement restarts the count.
    for (int k = 0; k < 3; k++) begin
      if (r_sync2[k] != r_error[5+k]) begin
        if (r_pin_cnt[k] == PIN_LAST) begin
          w_err_nxt[5+k]   = r_sync2[k];
          w_pin_cnt_nxt[k] = 16'd0;
        end else begin
          w_pin_cnt_nxt[k] = r_pin_cnt[k] + 16'd1;
        end
      end else begin
        w_pin_cnt_nxt[k] = 16'd0;
      end
    end
  end

  // Two-flop synchronizers for the asynchronous driver fault pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 3'b111;
      r_sync2 <= 3'b111;
    end else begin
      r_sync1 <= drv_fault_n;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce counters and the registered fault outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int ch = 0; ch < 5; ch++) r_cnt[ch] <= 4'd0;
      for (int k = 0; k < 3; k++) r_pin_cnt[k] <= 16'd0;
      r_error <= 8'hFF;
      r_any   <= 1'b0;
    end else begin
      for (int ch = 0; ch < 5; ch++) r_cnt[ch] <= w_cnt_nxt[ch];
      for (int k = 0; k < 3; k++) r_pin_cnt[k] <= w_pin_cnt_nxt[k];
      r_error <= w_err_nxt;
      r_any   <= ~&w_err_nxt;
    end
  end

  assign error     = r_error;
  assign any_fault = r_any;

endmodule

// File: tb/tb_fault_detect.sv
// Randomized + directed bench for fault_detect against a history-based model.
module tb_fault_detect;

  localparam int I_MAX   = 1800;
  localparam int U_MAX   = 3500;
  localparam int U_MIN   = 500;
  localparam int DEB_N   = 4;
  localparam int PIN_DEB = 1000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        adc_valid = 1'b0;
  logic [11:0] i_a = 12'd0, i_b = 12'd0, i_c = 12'd0, u_dc = 12'd2000;
  logic [2:0]  drv_fault_n = 3'b111;
  logic [7:0]  error;
  logic        any_fault;

  int n_total = 0;
  int n_bad   = 0;

  fault_detect #(.I_MAX(I_MAX), .U_MAX(U_MAX), .U_MIN(U_MIN),
                 .DEB_N(DEB_N), .PIN_DEB(PIN_DEB)) dut (
    .clk(clk), .reset_n(reset_n), .adc_valid(adc_valid),
    .i_a(i_a), .i_b(i_b), .i_c(i_c), .u_dc(u_dc),
    .drv_fault_n(drv_fault_n), .error(error), .any_fault(any_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference model: per-channel history of trip outcomes on valid samples;
  // a channel is faulted when its last DEB_N samples all tripped.
  bit [15:0] m_hist [5];
  bit [15:0] m_pc;
  bit        m_run;
  bit [2:0]  m_s1, m_s2, m_lvl, m_perr;
  int        m_len [3];

  function automatic bit [15:0] deb_mask();
    return 16'((1 << DEB_N) - 1);
  endfunction

  function automatic logic [7:0] m_err();
    logic [7:0] e;
    for (int ch = 0; ch < 5; ch++) e[ch] = ((m_hist[ch] & deb_mask()) != deb_mask());
    e[7:5] = m_perr;
    return e;
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < 5; ch++) m_hist[ch] = 16'd0;
    m_pc = 16'd0; m_run = 1'b0;
    m_s1 = 3'b111; m_s2 = 3'b111; m_lvl = 3'b111; m_perr = 3'b111;
    for (int k = 0; k < 3; k++) m_len[k] = 0;
  endtask

  task automatic model_step();
    logic [11:0] raw;
    int v, mag;
    bit trip;
    if (adc_valid) begin
      for (int ch = 0; ch < 3; ch++) begin
        raw = (ch == 0) ? i_a : (ch == 1) ? i_b : i_c;
        v = int'($signed(raw));
        mag = (v < 0) ? -v : v;
        trip = (mag > I_MAX);
        m_hist[ch] = {m_hist[ch][14:0], trip};
      end
      m_hist[3] = {m_hist[3][14:0], (int'(u_dc) > U_MAX)};
      m_hist[4] = {m_hist[4][14:0], (int'(u_dc) < U_MIN)};
`ifdef UV_STARTUP_MASK_EN
      if (!m_run) begin
        m_hist[4] = 16'd0;
        m_pc = {m_pc[14:0], (int'(u_dc) >= U_MIN)};
        if ((m_pc & deb_mask()) == deb_mask()) m_run = 1'b1;
      end
`endif
    end
    for (int k = 0; k < 3; k++) begin
      if (m_len[k] > 0 && m_s2[k] == m_lvl[k]) m_len[k]++;
      else begin m_len[k] = 1; m_lvl[k] = m_s2[k]; end
      if (m_len[k] >= PIN_DEB) m_perr[k] = m_lvl[k];
    end
    m_s2 = m_s1;
    m_s1 = drv_fault_n;
  endtask

  task automatic cyc(input string tag);
    logic [7:0] e;
    @(posedge clk);
    model_step();
    @(negedge clk);
    e = m_err();
    chk({tag, "/err"}, error, e);
    chk({tag, "/any"}, any_fault, (e != 8'hFF));
  endtask

  task automatic sample(input int ia, input int ib, input int ic, input int u, input string tag);
    adc_valid = 1'b1;
    i_a = 12'(ia); i_b = 12'(ib); i_c = 12'(ic); u_dc = 12'(u);
    cyc(tag);
    adc_valid = 1'b0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk({tag, "/rst_err"}, error, 8'hFF);
    chk({tag, "/rst_any"}, any_fault, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  function automatic int rnd_i();
    int mag;
    bit neg;
    mag = int'($urandom_range(1750, 2048));
    neg = 1'($urandom_range(0, 1));
    if (!neg && mag == 2048) mag = 2047;
    return neg ? -mag : mag;
  endfunction

  function automatic int rnd_u();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(3450, 3600));
      1:       return int'($urandom_range(400, 600));
      2:       return int'($urandom_range(0, 4095));
      default: return int'($urandom_range(450, 3550));
    endcase
  endfunction

  initial begin
    int hold [3];
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_err", error, 8'hFF);
    chk("reset_any", any_fault, 1'b0);
    reset_n = 1'b1;

    // Overcurrent on A: three samples stay clear, the fourth trips.
    for (int i = 0; i < 3; i++) sample(1801, 0, 0, 2000, "oc_a");
    chk("oc_a_3", error, 8'hFF);
    sample(1801, 0, 0, 2000, "oc_a");
    chk("oc_a_4", error[0], 1'b0);
    chk("oc_a_any", any_fault, 1'b1);
    sample(0, 0, 0, 2000, "oc_a_clr");
    chk("oc_a_clr", error[0], 1'b1);

    // -2048 magnitude on B, cleared by a single good sample.
    for (int i = 0; i < 4; i++) sample(0, -2048, 0, 2000, "oc_b");
    chk("oc_b_trip", error[1], 1'b0);
    sample(0, 0, 0, 2000, "oc_b_clr");
    chk("oc_b_clr", error[1], 1'b1);

    // Overvoltage strictly above U_MAX only.
    for (int i = 0; i < 4; i++) sample(0, 0, 0, 3501, "ov");
    chk("ov_trip", error[3], 1'b0);
    for (int i = 0; i < 4; i++) sample(0, 0, 0, 3500, "ov_eq");
    chk("ov_eq", error[3], 1'b1);

    // Undervoltage from reset, with and without startup masking.
    async_reset("uv");
    for (int i = 0; i < 10; i++) begin
      sample(0, 0, 0, 100, "uv_low");
`ifdef UV_STARTUP_MASK_EN
      if (i == 3 || i == 9) chk("uv_masked", error[4], 1'b1);
`else
      if (i == 3 || i == 9) chk("uv_active", error[4], 1'b0);
`endif
    end
    for (int i = 0; i < 4; i++) sample(0, 0, 0, 600, "uv_ok");
    chk("uv_ok", error[4], 1'b1);
    for (int i = 0; i < 4; i++) sample(0, 0, 0, 499, "uv_499");
    chk("uv_499", error[4], 1'b0);

    // Driver pin 1: 999 low cycles is not enough; 1000 is; release likewise.
    drv_fault_n = 3'b101;
    idle(999, "pin_short");
    drv_fault_n = 3'b111;
    idle(1010, "pin_short_rel");
    chk("pin_short", error[6], 1'b1);
    drv_fault_n = 3'b101;
    idle(1001, "pin_low");
    chk("pin_low_early", error[6], 1'b1);
    idle(1, "pin_low");
    chk("pin_low", error[6], 1'b0);
    idle(50, "pin_hold");
    drv_fault_n = 3'b111;
    idle(1001, "pin_high");
    chk("pin_high_early", error[6], 1'b0);
    idle(1, "pin_high");
    chk("pin_high", error[6], 1'b1);

    // Three simultaneous faults, async reset mid-activity, restart from zero.
    for (int i = 0; i < 4; i++) sample(1900, 0, -1900, 3600, "multi");
    chk("multi", error, 8'hF2);
    async_reset("multi");
    for (int i = 0; i < 3; i++) sample(1900, 0, -1900, 3600, "restart");
    chk("restart_3", error, 8'hFF);
    sample(1900, 0, -1900, 3600, "restart");
    chk("restart_4", error, 8'hF2);

    // Randomized traffic with slowly toggling pins.
    for (int k = 0; k < 3; k++) hold[k] = 0;
    for (int n = 0; n < 8000; n++) begin
      for (int k = 0; k < 3; k++) begin
        if (hold[k] == 0) begin
          drv_fault_n[k] = 1'($urandom_range(0, 1));
          hold[k] = int'($urandom_range(50, 1600));
        end else begin
          hold[k]--;
        end
      end
      adc_valid = ($urandom_range(0, 2) != 0);
      i_a = 12'(rnd_i()); i_b = 12'(rnd_i()); i_c = 12'(rnd_i());
      u_dc = 12'(rnd_u());
      if (n == 4000) async_reset("rnd");
      cyc("rnd");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
